// File: rtl/ins_fetch_pkg.sv
// Shared fetch definitions: instruction width, halt encoding and fetch state.
// Decode and the ROM wrapper use the same constants.
package ins_fetch_pkg;

    localparam int INS_W = 16;
    localparam logic [INS_W-1:0] HALT_WORD = 16'hEFFF;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ins_fetch.sv
// Instruction fetch: drives the ROM byte address, tags returned words with the
// address they came from, and presents them to decode over valid/ready.
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int NS = 7
) (
    input  logic             clk,
    input  logic             rst,
    output logic [NS:0]      pc_out,
    input  logic [INS_W-1:0] ins_in,
    output logic [INS_W-1:0] ir,
    output logic [NS:0]      ir_pc,
    output logic             ir_valid,
    input  logic             ir_ready,
    input  logic             redirect,
    input  logic [NS:0]      redirect_pc,
    output logic             halted
);

    localparam logic [NS:0] STEP = {{(NS-1){1'b0}}, 2'b10};

    fetch_state_e     state_q, state_d;
    logic [NS:0]      pc_q, pc_d;
    logic [NS:0]      exp_pc_q, exp_pc_d;
    logic [NS:0]      req_pc_q, req_pc_d;
    logic             req_v_q, req_v_d;
    logic [INS_W-1:0] ir_q, ir_d;
    logic [NS:0]      ir_pc_q, ir_pc_d;
    logic             ir_valid_q, ir_valid_d;
    logic             run, capture;
    logic [NS:0]      target;

    // Ask for the word after E when the ROM is already on E, otherwise (re)request E.
    // A word whose tag no longer matches exp_pc is simply never captured.
    function automatic logic [NS:0] next_pc(input logic [NS:0] cur, input logic [NS:0] e);
        return (cur == e) ? e + STEP : e;
    endfunction

    always_comb begin
        run        = (state_q == FETCH_RUN);
        target     = {redirect_pc[NS:1], 1'b0};
        capture    = run && req_v_q && (req_pc_q == exp_pc_q)
                     && (!ir_valid_q || ir_ready) && !redirect;
        state_d    = state_q;
        pc_d       = pc_q;
        exp_pc_d   = exp_pc_q;
        req_pc_d   = run ? pc_q : req_pc_q;
        req_v_d    = run;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;

        if (run && redirect) begin
            exp_pc_d   = target;
            pc_d       = target;
            ir_valid_d = 1'b0;
        end else begin
            if (capture) begin
                ir_d       = ins_in;
                ir_pc_d    = exp_pc_q;
                ir_valid_d = 1'b1;
                exp_pc_d   = exp_pc_q + STEP;
                if (ins_in == HALT_WORD) begin
                    state_d = FETCH_HALT;
                end
            end else if (ir_valid_q && ir_ready) begin
                ir_valid_d = 1'b0;
            end
            if (run) begin
                pc_d = next_pc(pc_q, exp_pc_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH_RUN;
            pc_q       <= '0;
            exp_pc_q   <= '0;
            req_pc_q   <= '0;
            req_v_q    <= 1'b0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            exp_pc_q   <= exp_pc_d;
            req_pc_q   <= req_pc_d;
            req_v_q    <= req_v_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign pc_out   = pc_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;
    assign halted   = (state_q == FETCH_HALT);

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: ROM model, stream scoreboard checked every cycle,
// directed scenarios with literal expectations, and a randomized phase.
module tb_ins_fetch;
    import ins_fetch_pkg::*;

    localparam int NS = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NS:0]   pc_out;
    logic [15:0]   ins_in = 16'h0;
    logic [15:0]   ir;
    logic [NS:0]   ir_pc;
    logic          ir_valid;
    logic          ir_ready = 1'b0;
    logic          redirect = 1'b0;
    logic [NS:0]   redirect_pc = '0;
    logic          halted;

    logic [15:0]   rom [0:127];

    int total = 0;
    int bad   = 0;

    ins_fetch #(.NS(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_out     (pc_out),
        .ins_in     (ins_in),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: output reflects the address sampled at the last edge.
    always @(posedge clk) ins_in <= rom[pc_out[7:1]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream model: the next delivered word must carry address m_next and the
    // ROM data at that address; redirects move m_next, handshakes advance it.
    logic [NS:0] m_next, pc_hold, prev_ir_pc;
    logic [15:0] prev_ir;
    bit          m_halt, m_done, prev_stall, was_halt;
    int          idle;

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_data", 32'({ir, ir_pc, pc_out}), 32'h0);
            chk("rst_flags", 32'({ir_valid, halted}), 32'h0);
            m_next = '0; m_halt = 0; m_done = 0; prev_stall = 0; idle = 0;
        end else begin
            was_halt = m_halt;
            if (ir_valid && ir == HALT_WORD) m_halt = 1;
            chk("halted", 32'(halted), 32'(m_halt));
            chk("pc_even", 32'(pc_out[0]), 32'h0);
            if (was_halt) chk("pc_frozen", 32'(pc_out), 32'(pc_hold));
            else pc_hold = pc_out;
            if (m_done) chk("valid_after_halt", 32'(ir_valid), 32'h0);
            if (prev_stall) begin
                chk("stall_ir", 32'(ir), 32'(prev_ir));
                chk("stall_pc", 32'(ir_pc), 32'(prev_ir_pc));
                chk("stall_v", 32'(ir_valid), 32'h1);
            end
            if (ir_valid) begin
                chk("tag", 32'(ir_pc), 32'(m_next));
                chk("data", 32'(ir), 32'(rom[ir_pc[7:1]]));
            end
            if (ir_valid || redirect || m_halt) idle = 0;
            else idle++;
            if (idle > 3) begin
                chk("progress", 32'(idle), 32'd3);
                idle = 0;
            end
            prev_stall = ir_valid && !ir_ready && !redirect;
            prev_ir    = ir;
            prev_ir_pc = ir_pc;
            if (m_halt && ir_valid && ir_ready) m_done = 1;
            if (redirect && !m_halt) m_next = {redirect_pc[NS:1], 1'b0};
            else if (ir_valid && ir_ready) m_next = 8'(m_next + 8'd2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [NS:0] pc_h;
        for (int i = 0; i < 128; i++) rom[i] = 16'h1000 + 16'(i * 3);
        rom[0]  = 16'hF120; rom[1]  = 16'hF121; rom[2] = 16'h93FF; rom[3] = 16'h834C;
        rom[10] = 16'h9402; rom[11] = 16'hA694; rom[27] = 16'hEFFF;

        // reset state
        rst = 1'b0; ir_ready = 1'b1;
        repeat (2) tick();
        chk("reset_pc_out", 32'(pc_out), 32'h0);
        chk("reset_ir", 32'(ir), 32'h0);
        chk("reset_ir_pc", 32'(ir_pc), 32'h0);
        chk("reset_ir_valid", 32'(ir_valid), 32'h0);
        chk("reset_halted", 32'(halted), 32'h0);
        rst = 1'b1;

        // first word after two edges, then one per cycle
        tick(); chk("first_v_edge1", 32'(ir_valid), 32'h0);
        tick(); chk("first_v", 32'(ir_valid), 32'h1);
        chk("w0_ir", 32'(ir), 32'hF120); chk("w0_pc", 32'(ir_pc), 32'h00);
        tick(); chk("w1_ir", 32'(ir), 32'hF121); chk("w1_pc", 32'(ir_pc), 32'h02);
        tick(); chk("w2_ir", 32'(ir), 32'h93FF); chk("w2_pc", 32'(ir_pc), 32'h04);

        // downstream stall
        ir_ready = 1'b0;
        repeat (3) begin
            tick();
            chk("hold_ir", 32'(ir), 32'h93FF);
            chk("hold_pc", 32'(ir_pc), 32'h04);
            chk("hold_v", 32'(ir_valid), 32'h1);
        end
        ir_ready = 1'b1;
        tick();
        n = 0;
        while (!ir_valid && n < 5) begin tick(); n++; end
        chk("resume_ir", 32'(ir), 32'h834C);
        chk("resume_pc", 32'(ir_pc), 32'h06);
        tick();

        // redirect while streaming
        redirect = 1'b1; redirect_pc = 8'h14;
        tick(); chk("redir_flush", 32'(ir_valid), 32'h0);
        redirect = 1'b0;
        tick(); chk("redir_bubble", 32'(ir_valid), 32'h0);
        tick(); chk("redir_v", 32'(ir_valid), 32'h1);
        chk("redir_ir", 32'(ir), 32'h9402); chk("redir_pc", 32'(ir_pc), 32'h14);
        tick(); chk("redir_ir2", 32'(ir), 32'hA694); chk("redir_pc2", 32'(ir_pc), 32'h16);

        // redirect with ir_ready in the same cycle, odd target
        redirect = 1'b1; redirect_pc = 8'h15;
        tick(); chk("odd_flush", 32'(ir_valid), 32'h0);
        redirect = 1'b0;
        tick(); tick();
        chk("odd_v", 32'(ir_valid), 32'h1);
        chk("odd_ir", 32'(ir), 32'h9402); chk("odd_pc", 32'(ir_pc), 32'h14);

        // randomized phase with the halt word masked out
        rst = 1'b0; rom[27] = 16'h5A5A;
        tick(); rst = 1'b1;
        repeat (600) begin
            ir_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 8'hFA : 8'($urandom_range(0, 255));
            tick();
        end
        redirect = 1'b0; ir_ready = 1'b1;

        // asynchronous reset mid-stream
        rst = 1'b0; rom[27] = 16'hEFFF;
        tick(); rst = 1'b1;
        n = 0;
        while (!(ir_valid && ir_pc == 8'h0A) && n < 20) begin tick(); n++; end
        chk("reach_0a", 32'(ir_pc), 32'h0A);
        rst = 1'b0;
        #1;
        chk("async_pc_out", 32'(pc_out), 32'h0);
        chk("async_ir", 32'(ir), 32'h0);
        chk("async_ir_pc", 32'(ir_pc), 32'h0);
        chk("async_ir_valid", 32'(ir_valid), 32'h0);
        tick(); rst = 1'b1;
        tick(); tick();
        chk("rerun_v", 32'(ir_valid), 32'h1);
        chk("rerun_ir", 32'(ir), 32'hF120); chk("rerun_pc", 32'(ir_pc), 32'h00);

        // run to the halt word
        n = 0;
        while (!(ir_valid && ir == 16'hEFFF) && n < 60) begin tick(); n++; end
        chk("halt_ir", 32'(ir), 32'hEFFF);
        chk("halt_pc", 32'(ir_pc), 32'h36);
        chk("halt_flag", 32'(halted), 32'h1);
        pc_h = pc_out;
        redirect = 1'b1; redirect_pc = 8'h00;
        tick();
        redirect = 1'b0;
        repeat (5) tick();
        chk("halt_no_valid", 32'(ir_valid), 32'h0);
        chk("halt_pc_frozen", 32'(pc_out), 32'(pc_h));
        chk("halt_stays", 32'(halted), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
